slsu: RTL and testbench



---
 rtl/score_pkg.sv | 34 +++
 rtl/slsu_extend.sv | 28 ++
 rtl/slsu.sv | 210 +++++++++++++++++++++
 tb/tb_slsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared core definitions: funct3 encodings, memory access sizes and LSU states.
// Also holds the funct3 legality check used by the load/store unit.
package score_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   // Stores only have the signed encodings; unsigned variants exist for loads only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/slsu_extend.sv
// Sign/zero extension of load data from 8, 16 or 32 bits, selected by funct3.
module slsu_extend
   import score_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic fill_b;
   logic fill_h;

   // funct3[2] set means an unsigned load (LBU/LHU)
   assign fill_b = ~funct3[2] & data_in[7];
   assign fill_h = ~funct3[2] & data_in[15];

   always_comb begin
      data_out = data_in;
      case (funct3[1:0])
         MEM_BYTE: data_out = {{(DATA_WIDTH-8){fill_b}}, data_in[7:0]};
         MEM_HALF: data_out = {{(DATA_WIDTH-16){fill_h}}, data_in[15:0]};
         default:  data_out = data_in;
      endcase
   end

endmodule

// File: rtl/slsu.sv
// Load/store unit: one request at a time, aligned accesses in one memory cycle,
// misaligned ones split into byte accesses, response returned over valid/ready.
//
// state  | meaning
// IDLE   | ready for a request; computes address, legality and bounds on accept
// ACCESS | single aligned memory cycle
// SPLIT  | one byte access per cycle, idx 0..n-1
// RESP   | response held on rsp_* until rsp_ready_i
module slsu
   import score_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [DATA_WIDTH-1:0] req_base_i,
   input  logic [DATA_WIDTH-1:0] req_offset_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [4:0]            req_rd_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [4:0]            rsp_rd_o,
   output logic                  rsp_err_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [1:0]            mem_size_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [DATA_WIDTH:0] ADDR_LIMIT = (DATA_WIDTH+1)'(MEM_SIZE - 3);

   lsu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [4:0]            rd_q, rd_d;
   logic [1:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] eff_addr;
   logic [DATA_WIDTH:0]   req_span;
   logic [DATA_WIDTH:0]   last_addr;
   logic                  req_aligned;
   logic                  req_fault;
   logic [1:0]            last_idx;
   logic [4:0]            byte_sel;
   logic [DATA_WIDTH-1:0] asm_merge;
   logic [DATA_WIDTH-1:0] ext_in;
   logic [DATA_WIDTH-1:0] ext_out;

   assign eff_addr = req_base_i + req_offset_i;

   // Bounds use 33 bits so a wrapped address can never sneak under the limit.
   always_comb begin
      req_aligned = 1'b1;
      req_span    = '0;
      case (req_funct3_i[1:0])
         2'b00: begin
            req_aligned = 1'b1;
            req_span    = '0;
         end
         2'b01: begin
            req_aligned = ~eff_addr[0];
            req_span    = (DATA_WIDTH+1)'(1);
         end
         default: begin
            req_aligned = (eff_addr[1:0] == 2'b00);
            req_span    = (DATA_WIDTH+1)'(3);
         end
      endcase
      last_addr = {1'b0, eff_addr} + (req_aligned ? '0 : req_span);
      req_fault = !f3_legal(req_we_i, req_funct3_i) || (last_addr >= ADDR_LIMIT);
   end

   assign last_idx = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign byte_sel = {idx_q, 3'b000};

   always_comb begin
      asm_merge = asm_q;
      asm_merge[byte_sel +: 8] = mem_rdata_i[7:0];
   end

   assign ext_in = (state_q == SPLIT) ? asm_merge : mem_rdata_i;

   slsu_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_extend (
      .funct3   (f3_q),
      .data_in  (ext_in),
      .data_out (ext_out)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      f3_d        = f3_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      idx_d       = idx_q;
      asm_d       = asm_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      req_ready_o = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      mem_size_o  = 2'b00;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               addr_d  = eff_addr;
               we_d    = req_we_i;
               f3_d    = req_funct3_i;
               wdata_d = req_wdata_i;
               rd_d    = req_rd_i;
               idx_d   = 2'd0;
               asm_d   = '0;
               rdata_d = '0;
               err_d   = req_fault;
               if (req_fault) begin
                  state_d = RESP;
               end else if (req_aligned) begin
                  state_d = ACCESS;
               end else begin
                  state_d = SPLIT;
               end
            end
         end
         ACCESS: begin
            mem_read_o  = ~we_q;
            mem_write_o = we_q;
            mem_size_o  = f3_q[1:0];
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if (!we_q) begin
               rdata_d = ext_out;
            end
            state_d = RESP;
         end
         SPLIT: begin
            mem_read_o  = ~we_q;
            mem_write_o = we_q;
            mem_size_o  = MEM_BYTE;
            mem_addr_o  = addr_q + DATA_WIDTH'(idx_q);
            mem_wdata_o = {{(DATA_WIDTH-8){1'b0}}, wdata_q[byte_sel +: 8]};
            asm_d       = asm_merge;
            if (idx_q == last_idx) begin
               if (!we_q) begin
                  rdata_d = ext_out;
               end
               state_d = RESP;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         wdata_q <= '0;
         rd_q    <= '0;
         idx_q   <= 2'd0;
         asm_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_rd_o    = rd_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_slsu.sv
// Directed bench for slsu with a byte-array memory model and a response scoreboard.
module tb_slsu;
   import score_pkg::*;

   localparam int MEM_SIZE = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_base_i;
   logic [31:0] req_offset_i;
   logic [31:0] req_wdata_i;
   logic [4:0]  req_rd_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic [4:0]  rsp_rd_o;
   logic        rsp_err_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [1:0]  mem_size_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   always #5 clk = ~clk;

   slsu #(
      .DATA_WIDTH (32),
      .MEM_SIZE   (MEM_SIZE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_base_i   (req_base_i),
      .req_offset_i (req_offset_i),
      .req_wdata_i  (req_wdata_i),
      .req_rd_i     (req_rd_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_rd_o     (rsp_rd_o),
      .rsp_err_o    (rsp_err_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .mem_size_o   (mem_size_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i)
   );

   // Data memory model: combinational read (byte/half sign-extended), write per size.
   logic [7:0]  mem [MEM_SIZE];
   logic [7:0]  rb  [4];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] last_wr_addr = '0;
   logic [1:0]  last_wr_size = '0;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rb[k] = ((mem_addr_o + 32'(k)) < 32'(MEM_SIZE)) ? mem[mem_addr_o + 32'(k)] : 8'h00;
      end
      case (mem_size_o)
         2'b00:   mem_rdata_i = {{24{rb[0][7]}}, rb[0]};
         2'b01:   mem_rdata_i = {{16{rb[1][7]}}, rb[1], rb[0]};
         default: mem_rdata_i = {rb[3], rb[2], rb[1], rb[0]};
      endcase
   end

   always @(negedge clk) begin
      if (mem_read_o) rd_cnt++;
      if (mem_write_o) begin
         wr_cnt++;
         last_wr_addr = mem_addr_o;
         last_wr_size = mem_size_o;
         for (int k = 0; k < 4; k++) begin
            if ((k == 0 || (k == 1 && mem_size_o != 2'b00) || mem_size_o == 2'b10) &&
                (mem_addr_o + 32'(k)) < 32'(MEM_SIZE)) begin
               mem[mem_addr_o + 32'(k)] = mem_wdata_o[8*k +: 8];
            end
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_nrd, input int exp_nwr, input string tag);
      exp_t e;
      int   rd0, wr0, lat;
      bit   got;
      e = '{exp_rdata, rd, exp_err, exp_lat, exp_nrd, exp_nwr};
      @(negedge clk);
      chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_base_i   = base;
      req_offset_i = off;
      req_wdata_i  = wdata;
      req_rd_i     = rd;
      rsp_ready_i  = 1'b1;
      sb.push_back(e);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      req_valid_i = 1'b0;
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 20) begin
         if (rsp_valid_o) got = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
      e = sb.pop_front();
      if (got) begin
         chk({tag, "_rdata"}, rsp_rdata_o, e.rdata);
         chk({tag, "_rd"},    32'(rsp_rd_o), 32'(e.rd));
         chk({tag, "_err"},   32'(rsp_err_o), 32'(e.err));
         chk({tag, "_lat"},   32'(lat), 32'(e.lat));
         chk({tag, "_nread"}, 32'(rd_cnt - rd0), 32'(e.nrd));
         chk({tag, "_nwrite"}, 32'(wr_cnt - wr0), 32'(e.nwr));
      end
      @(posedge clk);
   endtask

   initial begin
      int lat;
      bit got;
      int rd0;

      for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
      mem[32'h10]  = 8'h80;
      mem[32'h3FC] = 8'h99;
      for (int i = 32'h41; i <= 32'h44; i++) mem[i] = 8'h55;

      rst = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
      req_base_i = '0; req_offset_i = '0; req_wdata_i = '0; req_rd_i = '0;
      rsp_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_err",   32'(rsp_err_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_rsp_rd",    32'(rsp_rd_o), 32'd0);
      chk("rst_mem_en",    {30'd0, mem_read_o, mem_write_o}, 32'd0);
      chk("rst_mem_bus",   mem_addr_o | mem_wdata_o | 32'(mem_size_o), 32'd0);
      rst = 1'b0;

      // aligned store/load
      do_req(1'b1, F3_W, 32'h100, 32'd4, 32'hCAFEBABE, 5'd3, 32'h0, 1'b0, 2, 0, 1, "sw_104");
      chk("sw_104_waddr", last_wr_addr, 32'h104);
      chk("sw_104_wsize", 32'(last_wr_size), 32'd2);
      do_req(1'b0, F3_W, 32'h100, 32'd4, 32'h0, 5'd4, 32'hCAFEBABE, 1'b0, 2, 1, 0, "lw_104");

      // byte extension
      do_req(1'b0, F3_B,  32'h10, 32'd0, 32'h0, 5'd5, 32'hFFFFFF80, 1'b0, 2, 1, 0, "lb_10");
      do_req(1'b0, F3_BU, 32'h10, 32'd0, 32'h0, 5'd6, 32'h00000080, 1'b0, 2, 1, 0, "lbu_10");

      // misaligned half store/load
      do_req(1'b1, F3_H, 32'h20, 32'd1, 32'h0000BEEF, 5'd7, 32'h0, 1'b0, 3, 0, 2, "sh_21");
      chk("sh_21_mem21", 32'(mem[32'h21]), 32'hEF);
      chk("sh_21_mem22", 32'(mem[32'h22]), 32'hBE);
      do_req(1'b0, F3_HU, 32'h20, 32'd1, 32'h0, 5'd8, 32'h0000BEEF, 1'b0, 3, 2, 0, "lhu_21");
      do_req(1'b0, F3_H,  32'h20, 32'd1, 32'h0, 5'd9, 32'hFFFFBEEF, 1'b0, 3, 2, 0, "lh_21");

      // bounds near the top of memory
      do_req(1'b0, F3_W, 32'h400, 32'hFFFFFFFB, 32'h0, 5'd10, 32'h0, 1'b1, 1, 0, 0, "lw_3fb");
      do_req(1'b1, F3_W, 32'h3F8, 32'd0, 32'h11223344, 5'd11, 32'h0, 1'b0, 2, 0, 1, "sw_3f8");
      do_req(1'b0, F3_W, 32'h3F0, 32'd9, 32'h0, 5'd12, 32'h99112233, 1'b0, 5, 4, 0, "lw_3f9");
      do_req(1'b0, F3_B, 32'h3FC, 32'd0, 32'h0, 5'd13, 32'hFFFFFF99, 1'b0, 2, 1, 0, "lb_3fc");
      do_req(1'b0, F3_B, 32'h3FD, 32'd0, 32'h0, 5'd14, 32'h0, 1'b1, 1, 0, 0, "lb_3fd");

      // address wrap
      do_req(1'b0, F3_BU, 32'hFFFFFFFF, 32'h11, 32'h0, 5'd15, 32'h00000080, 1'b0, 2, 1, 0, "wrap_ok");
      do_req(1'b0, F3_W, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd16, 32'h0, 1'b1, 1, 0, 0, "wrap_flt");

      // illegal funct3
      do_req(1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 5'd17, 32'h0, 1'b1, 1, 0, 0, "ld_f3_011");
      do_req(1'b1, 3'b100, 32'h100, 32'd0, 32'h12345678, 5'd18, 32'h0, 1'b1, 1, 0, 0, "st_f3_100");

      // response backpressure with the next request already waiting
      @(negedge clk);
      rd0 = rd_cnt;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_W;
      req_base_i = 32'h104; req_offset_i = 32'd0; req_rd_i = 5'd21;
      rsp_ready_i = 1'b0;
      sb.push_back('{32'hCAFEBABE, 5'd21, 1'b0, 2, 1, 0});
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid_o) got = 1'b1;
      end
      chk("hold_rsp_seen", 32'(got), 32'd1);
      begin
         exp_t e;
         e = sb.pop_front();
         for (int c = 0; c < 4; c++) begin
            chk("hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_rdata", rsp_rdata_o, e.rdata);
            chk("hold_rd",    32'(rsp_rd_o), 32'(e.rd));
            chk("hold_err",   32'(rsp_err_o), 32'(e.err));
            chk("hold_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk);
         end
      end
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("hold_after_valid", 32'(rsp_valid_o), 32'd0);
      chk("hold_after_ready", 32'(req_ready_o), 32'd1);
      chk("hold_nread", 32'(rd_cnt - rd0), 32'd1);

      // reset in the middle of a split store
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_W;
      req_base_i = 32'h40; req_offset_i = 32'd1; req_wdata_i = 32'hA1B2C3D4; req_rd_i = 5'd22;
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("rstsplit_wr0", 32'(mem_write_o), 32'd1);
      chk("rstsplit_addr0", mem_addr_o, 32'h41);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstsplit_ready", 32'(req_ready_o), 32'd1);
      chk("rstsplit_wr_off", 32'(mem_write_o), 32'd0);
      for (int c = 0; c < 3; c++) begin
         chk("rstsplit_no_rsp", 32'(rsp_valid_o), 32'd0);
         @(negedge clk);
      end
      chk("rstsplit_m41", 32'(mem[32'h41]), 32'hD4);
      chk("rstsplit_m42", 32'(mem[32'h42]), 32'hC3);
      chk("rstsplit_m43", 32'(mem[32'h43]), 32'h55);
      chk("rstsplit_m44", 32'(mem[32'h44]), 32'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
